// File: rtl/dma_pkg.sv
// Shared types and defaults for the block-copy DMA engine.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } dma_state_t;

    // Default number of cycles to wait for a memory completion.
    localparam int DMA_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dma_watchdog.sv
// Loadable down-counter used to bound the wait for a memory completion.
// expire is high while the count sits at zero; the count saturates there.
module dma_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    localparam logic [W-1:0] ONE  = W'(32'd1);
    localparam logic [W-1:0] ZERO = W'(32'd0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, then load, then a saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ZERO;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != ZERO)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == ZERO);

endmodule

// File: rtl/dma_engine.sv
// Block-copy initiator: streams a block as alternating single-word read and
// write requests with exactly one request outstanding at a time.
module dma_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = DMA_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid
);

    localparam int                  WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]     WD_LOAD  = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(32'd1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(32'd1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = LEN_WIDTH'(32'd0);

    dma_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic wd_clr_s, wd_load_s, wd_dec_s, wd_expire_s;

    dma_watchdog #(.W(WD_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wd_clr_s),
        .load     (wd_load_s),
        .load_val (WD_LOAD),
        .dec      (wd_dec_s),
        .expire   (wd_expire_s)
    );

    // Next-state, datapath and registered-output values. Outputs are derived
    // from the next state so the request strobe lines up with the REQ state.
    // An abort seen during a wait is remembered until the completion arrives.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        done_d       = 1'b0;
        wd_clr_s     = 1'b0;
        wd_load_s    = 1'b0;
        wd_dec_s     = 1'b0;

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                wd_clr_s     = 1'b1;
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    cnt_d   = len;
                    err_d   = 1'b0;
                    state_d = (len == LEN_ZERO) ? DONE : RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    wd_load_s = 1'b1;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                wd_dec_s = 1'b1;
                if (abort) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
                if (mem_valid) begin
                    data_d  = mem_rdata;
                    state_d = (abort || abort_pend_q) ? IDLE : WR_REQ;
                end else if (wd_expire_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    wd_load_s = 1'b1;
                    state_d   = WR_WAIT;
                end
            end
            WR_WAIT: begin
                wd_dec_s = 1'b1;
                if (abort) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
                if (mem_valid) begin
                    src_d = src_q + ADDR_ONE;
                    dst_d = dst_q + ADDR_ONE;
                    cnt_d = cnt_q - LEN_ONE;
                    if (abort || abort_pend_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == LEN_ONE) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (wd_expire_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            DONE: begin
                // A normal completion already pulsed done on entry; a
                // zero-length transfer pulses it on the way out instead.
                done_d  = ~done_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        mem_en_d    = (state_d == RD_REQ) || (state_d == WR_REQ);
        mem_wr_en_d = (state_d == WR_REQ);

        if (state_d == RD_REQ) begin
            mem_addr_d = src_d;
        end else if (state_d == WR_REQ) begin
            mem_addr_d = dst_d;
        end else begin
            mem_addr_d = mem_addr_q;
        end

        if (state_d == WR_REQ) begin
            mem_wdata_d = data_d;
        end else begin
            mem_wdata_d = mem_wdata_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_en_q     <= mem_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: table of copy jobs against a memory model,
// plus hand-written abort and mid-transfer reset sequences.
module tb_dma_engine;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, err, mem_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_valid = 1'b0;

    always #5 clk = ~clk;

    dma_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem  [0:65535];
    logic [DW-1:0] gold [0:65535];

    int   cyc = 0;
    int   t0 = 32'h7fff_ffff;
    bit   pend = 1'b0;
    int   pcnt = 0;
    logic pwr = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pdata = '0;
    logic prev_en = 1'b0;
    int   rsp_delay = 1;
    int   drop_idx = -1;
    int   req_n = 0;
    int   done_n = 0;
    int   done_rel = -1;
    int   err_rel = -1;
    int   busy_n = 0;
    bit   log_wr [$];
    logic [AW-1:0] log_addr [$];

    typedef struct {
        int s; int d; int n; int dly; int drop;
        int exp_err; int exp_done_n; int exp_reqs;
        int exp_done_rel; int exp_busy_n; int exp_err_rel;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [DW-1:0] pat(input int a);
        logic [15:0] lo;
        lo = a[15:0];
        return {~lo, lo};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder and activity monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (!rst_n) begin
            pend    = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    pend      = 1'b0;
                    mem_valid = 1'b1;
                    if (pwr) mem[paddr] = pdata;
                    else     mem_rdata  = mem[paddr];
                end
            end
            if (mem_en) begin
                checks++;
                if (pend || prev_en) begin
                    failures++;
                    $display("FAIL single_outstanding: got request at cycle %0d while busy, expected none", cyc - t0);
                end
                log_wr.push_back(mem_wr_en);
                log_addr.push_back(mem_addr);
                if (req_n != drop_idx) begin
                    pend  = 1'b1;
                    pwr   = mem_wr_en;
                    paddr = mem_addr;
                    pdata = mem_wdata;
                    pcnt  = (rsp_delay == 0) ? $urandom_range(5, 1) : rsp_delay;
                end
                req_n++;
            end
            prev_en = mem_en;
            if (done) begin
                done_n++;
                done_rel = cyc - t0;
            end
            if (err && err_rel < 0 && cyc > t0) err_rel = cyc - t0;
            if (busy && cyc > t0) busy_n++;
        end
    end

    task automatic clear_log();
        log_wr.delete();
        log_addr.delete();
        req_n = 0; done_n = 0; done_rel = -1; err_rel = -1; busy_n = 0;
    endtask

    task automatic launch(input int s, input int d, input int n);
        @(posedge clk); #2;
        clear_log();
        src_addr = s[15:0];
        dst_addr = d[15:0];
        len      = n[15:0];
        start    = 1'b1;
        t0       = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int i;
        i = 0;
        while (busy && i < 300) begin
            @(posedge clk); #2;
            i++;
        end
        if (i >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: got busy after 300 cycles, expected idle", nm);
        end
        repeat (3) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        vecs[0] = '{32'h0010, 32'h0100, 3, 1, -1, 0, 1, 6, 13, 13, -1};
        vecs[1] = '{32'h0010, 32'h0200, 3, 0, -1, 0, 1, 6, -1, -1, -1};
        vecs[2] = '{32'hFFFE, 32'h0300, 4, 1, -1, 0, 1, 8, 17, 17, -1};
        vecs[3] = '{32'h0400, 32'h0500, 0, 1, -1, 0, 1, 0, 2, 1, -1};
        vecs[4] = '{32'h0020, 32'h0600, 3, 1, 2, 1, 0, 3, -1, 13, 14};
        vecs[5] = '{32'h0020, 32'h0700, 3, 1, -1, 0, 1, 6, 13, 13, -1};

        for (int a = 0; a < 65536; a++) gold[a] = pat(a);
        gold[16'h0010] = 32'h0000_000A;
        gold[16'h0011] = 32'h0000_000B;
        gold[16'h0012] = 32'h0000_000C;
        for (int a = 0; a < 65536; a++) mem[a] = gold[a];

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_mem_en", 64'(mem_en), 64'd0);
        chk("reset_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;

        // Table of copy jobs.
        for (int v = 0; v < 6; v++) begin
            rsp_delay = vecs[v].dly;
            drop_idx  = vecs[v].drop;
            launch(vecs[v].s, vecs[v].d, vecs[v].n);
            wait_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_done_count", v), 64'(done_n), 64'(vecs[v].exp_done_n));
            chk($sformatf("v%0d_req_count", v), 64'(req_n), 64'(vecs[v].exp_reqs));
            if (vecs[v].exp_done_rel >= 0)
                chk($sformatf("v%0d_done_cycle", v), 64'(done_rel), 64'(vecs[v].exp_done_rel));
            if (vecs[v].exp_busy_n >= 0)
                chk($sformatf("v%0d_busy_cycles", v), 64'(busy_n), 64'(vecs[v].exp_busy_n));
            if (vecs[v].exp_err_rel >= 0)
                chk($sformatf("v%0d_err_cycle", v), 64'(err_rel), 64'(vecs[v].exp_err_rel));
            for (int k = 0; k < vecs[v].exp_reqs && k < log_wr.size(); k++) begin
                logic [AW-1:0] base, off, ea;
                base = ((k % 2) == 1) ? vecs[v].d[15:0] : vecs[v].s[15:0];
                off  = 16'(k / 2);
                ea   = base + off;
                chk($sformatf("v%0d_req%0d_wr", v, k), 64'(log_wr[k]), 64'(k % 2));
                chk($sformatf("v%0d_req%0d_addr", v, k), 64'(log_addr[k]), 64'(ea));
            end
            if (vecs[v].exp_err == 0) begin
                for (int i = 0; i < vecs[v].n; i++) begin
                    logic [AW-1:0] sa, da, oi;
                    oi = 16'(i);
                    sa = vecs[v].s[15:0] + oi;
                    da = vecs[v].d[15:0] + oi;
                    chk($sformatf("v%0d_data%0d", v, i), 64'(mem[da]), 64'(gold[sa]));
                end
            end
        end

        // Abort during the first write wait; start while busy must be ignored.
        rsp_delay = 4;
        drop_idx  = -1;
        launch(32'h0030, 32'h0800, 3);
        while (cyc < t0 + 7) begin
            @(posedge clk); #2;
        end
        abort = 1'b1;
        @(posedge clk); #2;
        abort    = 1'b0;
        src_addr = 16'h0040;
        dst_addr = 16'h0900;
        len      = 16'd5;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        while (cyc < t0 + 25) begin
            @(posedge clk); #2;
        end
        chk("abort_req_count", 64'(req_n), 64'd2);
        chk("abort_done_count", 64'(done_n), 64'd0);
        chk("abort_busy_cycles", 64'(busy_n), 64'd10);
        chk("abort_busy_final", 64'(busy), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        if (log_addr.size() >= 2) begin
            chk("abort_req0_addr", 64'(log_addr[0]), 64'h0030);
            chk("abort_req1_addr", 64'(log_addr[1]), 64'h0800);
            chk("abort_req1_wr", 64'(log_wr[1]), 64'd1);
        end
        chk("abort_write_data", 64'(mem[16'h0800]), 64'(gold[16'h0030]));

        // Reset in the middle of a transfer.
        rsp_delay = 2;
        launch(32'h0050, 32'h0A00, 4);
        while (cyc < t0 + 4) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_mem_en", 64'(mem_en), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("midreset_req_count", 64'(req_n), 64'd1);
        chk("midreset_done_count", 64'(done_n), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
